// File: rtl/strobe_capture.sv
// strobe_capture: syncs and glitch-filters EXT_STRB, one STRB_VALID per qualified strobe, latency SYNC_STAGES+FILTER_CYCLES+1.
// No backpressure: pulses are dropped (CAP_EN low, CLR, FULL -> OVERRUN); macro STRB_PARITY_EN adds EXT_PAR/PAR_ERR_CNT.
module strobe_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int MAX_STROBES   = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EXT_STRB,
  input  logic [7:0] EXT_DATA,
  input  logic       CAP_EN,
  input  logic       CLR,
`ifdef STRB_PARITY_EN
  input  logic       EXT_PAR,
  output logic [7:0] PAR_ERR_CNT,
`endif
  output logic [7:0] STRB_DATA,
  output logic       STRB_VALID,
  output logic [5:0] STRB_TOTAL,
  output logic       FULL,
  output logic       OVERRUN
);
  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_QUAL, ST_EMIT, ST_RELEASE} state_t;

  localparam logic [3:0] FILT_N = 4'(FILTER_CYCLES);
  localparam logic [5:0] MAX_N  = 6'(MAX_STROBES);
  localparam logic [2:0] WARM_N = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0]      strb_sync_q, strb_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  state_t     state_q, state_d;
  logic [3:0] filt_cnt_q, filt_cnt_d;
  logic [2:0] warm_cnt_q, warm_cnt_d;
  logic       cap_ok_q, cap_ok_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] strb_data_q, strb_data_d;
  logic       strb_valid_q, strb_valid_d;
  logic [5:0] total_q, total_d;
  logic       overrun_q, overrun_d;
  logic       s_strb;
  logic [7:0] s_data;
  logic       warm, latch_en, emit, byte_good, full;

`ifdef STRB_PARITY_EN
  logic [SYNC_STAGES-1:0] par_sync_q, par_sync_d;
  logic                   par_ok_q, par_ok_d;
  logic [7:0]             par_err_q, par_err_d;
`endif

  assign s_strb = strb_sync_q[SYNC_STAGES-1];
  assign s_data = data_sync_q[SYNC_STAGES-1];
  assign full   = (total_q == MAX_N);
  // A high s_strb that was sampled on the first edge after reset belongs to a strobe already in flight.
  assign warm   = (warm_cnt_q == WARM_N);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      filt_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (s_strb) begin
          if (warm) begin
            state_d    = ST_QUAL;
            filt_cnt_d = 4'd1;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (!s_strb) state_d = ST_IDLE;
      end
      ST_QUAL: begin
        if (!s_strb) begin
          state_d    = ST_IDLE;
          filt_cnt_d = 4'd0;
        end else if (filt_cnt_q >= FILT_N) begin
          state_d    = ST_EMIT;
          filt_cnt_d = 4'd0;
        end else begin
          filt_cnt_d = filt_cnt_q + 4'd1;
        end
      end
      ST_EMIT: begin
        state_d    = ST_RELEASE;
        filt_cnt_d = 4'd0;
      end
      ST_RELEASE: begin
        if (s_strb) begin
          filt_cnt_d = 4'd0;
        end else if (filt_cnt_q + 4'd1 >= FILT_N) begin
          state_d    = ST_IDLE;
          filt_cnt_d = 4'd0;
        end else begin
          filt_cnt_d = filt_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        filt_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    latch_en = (state_q == ST_QUAL) && s_strb && (filt_cnt_q >= FILT_N);
    emit     = (state_q == ST_EMIT);
  end

  always_comb begin
    strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], EXT_STRB};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], EXT_DATA};
    warm_cnt_d  = warm ? warm_cnt_q : warm_cnt_q + 3'd1;
    // Enable must hold for the whole qualification, so a late CAP_EN never yields a partial strobe.
    cap_ok_d = cap_ok_q;
    if (state_q == ST_IDLE)      cap_ok_d = CAP_EN;
    else if (state_q == ST_QUAL) cap_ok_d = cap_ok_q & CAP_EN;
    byte_d = latch_en ? s_data : byte_q;
`ifdef STRB_PARITY_EN
    par_sync_d = {par_sync_q[SYNC_STAGES-2:0], EXT_PAR};
    par_ok_d   = latch_en ? ^{par_sync_q[SYNC_STAGES-1], s_data} : par_ok_q;
    byte_good  = par_ok_q;
    par_err_d  = par_err_q;
    if (CLR)                                      par_err_d = 8'd0;
    else if (emit && !par_ok_q && par_err_q != 8'hFF) par_err_d = par_err_q + 8'd1;
`else
    byte_good = 1'b1;
`endif
    strb_valid_d = emit && cap_ok_q && CAP_EN && byte_good && !full && !CLR;
    strb_data_d  = strb_valid_d ? byte_q : strb_data_q;
    total_d = total_q;
    if (CLR)                        total_d = 6'd0;
    else if (strb_valid_q && !full) total_d = total_q + 6'd1;
    overrun_d = overrun_q;
    if (CLR)                                                  overrun_d = 1'b0;
    else if (emit && cap_ok_q && CAP_EN && byte_good && full) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      strb_sync_q  <= '0;
      data_sync_q  <= '0;
      warm_cnt_q   <= 3'd0;
      cap_ok_q     <= 1'b0;
      byte_q       <= 8'd0;
      strb_data_q  <= 8'd0;
      strb_valid_q <= 1'b0;
      total_q      <= 6'd0;
      overrun_q    <= 1'b0;
    end else begin
      strb_sync_q  <= strb_sync_d;
      data_sync_q  <= data_sync_d;
      warm_cnt_q   <= warm_cnt_d;
      cap_ok_q     <= cap_ok_d;
      byte_q       <= byte_d;
      strb_data_q  <= strb_data_d;
      strb_valid_q <= strb_valid_d;
      total_q      <= total_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef STRB_PARITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_sync_q <= '0;
      par_ok_q   <= 1'b0;
      par_err_q  <= 8'd0;
    end else begin
      par_sync_q <= par_sync_d;
      par_ok_q   <= par_ok_d;
      par_err_q  <= par_err_d;
    end
  end

  assign PAR_ERR_CNT = par_err_q;
`endif

  assign STRB_DATA  = strb_data_q;
  assign STRB_VALID = strb_valid_q;
  assign STRB_TOTAL = total_q;
  assign FULL       = full;
  assign OVERRUN    = overrun_q;
endmodule

// File: tb/tb_strobe_capture.sv
// Bench for strobe_capture: directed scenarios plus a randomized strobe sequence against a frame-level model.
`timescale 1ns/1ps
module tb_strobe_capture;
  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int MAXS = 32;
  localparam int LAT  = SYNC + FILT + 1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EXT_STRB;
  logic [7:0] EXT_DATA;
  logic       CAP_EN;
  logic       CLR;
  logic [7:0] STRB_DATA;
  logic       STRB_VALID;
  logic [5:0] STRB_TOTAL;
  logic       FULL;
  logic       OVERRUN;
`ifdef STRB_PARITY_EN
  logic       EXT_PAR;
  logic [7:0] PAR_ERR_CNT;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got_dat[$];
  int         got_cyc[$];
  logic       par_inv = 1'b0;

  strobe_capture #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .MAX_STROBES(MAXS)) dut (
    .CLK(CLK), .RST_N(RST_N), .EXT_STRB(EXT_STRB), .EXT_DATA(EXT_DATA),
    .CAP_EN(CAP_EN), .CLR(CLR),
`ifdef STRB_PARITY_EN
    .EXT_PAR(EXT_PAR), .PAR_ERR_CNT(PAR_ERR_CNT),
`endif
    .STRB_DATA(STRB_DATA), .STRB_VALID(STRB_VALID), .STRB_TOTAL(STRB_TOTAL),
    .FULL(FULL), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (STRB_VALID === 1'b1) begin
      got_dat.push_back(STRB_DATA);
      got_cyc.push_back(cyc);
    end
  end

  // t0 is the cycle count after the first edge that samples the strobe high.
  task automatic drive_strobe(input logic [7:0] d, input int hold, input int gap, output int t0);
    @(negedge CLK);
    got_dat.delete();
    got_cyc.delete();
    EXT_DATA = d;
`ifdef STRB_PARITY_EN
    EXT_PAR = ~(^d) ^ par_inv;
`endif
    EXT_STRB = 1'b1;
    t0 = cyc + 1;
    repeat (hold) @(negedge CLK);
    EXT_STRB = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; EXT_STRB = 1'b0; EXT_DATA = 8'h00; CAP_EN = 1'b1; CLR = 1'b0;
`ifdef STRB_PARITY_EN
    EXT_PAR = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    checks++;
    if ({STRB_VALID, STRB_DATA, STRB_TOTAL, FULL, OVERRUN} !== 17'd0) begin
      errors++;
      $display("FAIL reset_in: got v=%b d=%h t=%0d f=%b o=%b exp all 0", STRB_VALID, STRB_DATA, STRB_TOTAL, FULL, OVERRUN);
    end
`ifdef STRB_PARITY_EN
    checks++;
    if (PAR_ERR_CNT !== 8'd0) begin errors++; $display("FAIL reset_par: got %0d exp 0", PAR_ERR_CNT); end
`endif
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if ({STRB_VALID, STRB_DATA, STRB_TOTAL, FULL, OVERRUN} !== 17'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h t=%0d f=%b o=%b exp all 0", STRB_VALID, STRB_DATA, STRB_TOTAL, FULL, OVERRUN);
    end
  endtask

  task automatic test_single();
    int t0;
    drive_strobe(8'hA5, 10, 10, t0);
    checks++;
    if (got_dat.size() != 1) begin errors++; $display("FAIL single_count: got %0d exp 1", got_dat.size()); end
    if (got_dat.size() >= 1) begin
      checks++;
      if (got_dat[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", got_dat[0]); end
      checks++;
      if (got_cyc[0] - t0 != LAT) begin errors++; $display("FAIL single_latency: got %0d exp %0d", got_cyc[0] - t0, LAT); end
    end
    checks++;
    if (STRB_TOTAL !== 6'd1) begin errors++; $display("FAIL single_total: got %0d exp 1", STRB_TOTAL); end
  endtask

  task automatic test_glitch();
    int t0;
    for (int h = 1; h < FILT; h++) begin
      drive_strobe(8'h3F, h, 10, t0);
      checks++;
      if (got_dat.size() != 0) begin errors++; $display("FAIL glitch_count h=%0d: got %0d exp 0", h, got_dat.size()); end
      checks++;
      if (STRB_TOTAL !== 6'd1) begin errors++; $display("FAIL glitch_total h=%0d: got %0d exp 1", h, STRB_TOTAL); end
    end
  endtask

  task automatic test_full();
    int t0;
    pulse_clr();
    for (int i = 0; i <= MAXS; i++) begin
      drive_strobe(8'(i), 6, 10, t0);
      checks++;
      if (got_dat.size() != ((i < MAXS) ? 1 : 0)) begin
        errors++; $display("FAIL full_count i=%0d: got %0d exp %0d", i, got_dat.size(), (i < MAXS) ? 1 : 0);
      end
      if (i < MAXS && got_dat.size() == 1) begin
        checks++;
        if (got_dat[0] !== 8'(i)) begin errors++; $display("FAIL full_data i=%0d: got %h exp %h", i, got_dat[0], 8'(i)); end
      end
      if (i == MAXS - 1) begin
        checks++;
        if ({FULL, OVERRUN} !== 2'b10) begin errors++; $display("FAIL full_at_max: got f=%b o=%b exp f=1 o=0", FULL, OVERRUN); end
      end
    end
    checks++;
    if ({STRB_TOTAL, FULL, OVERRUN} !== {6'(MAXS), 2'b11}) begin
      errors++; $display("FAIL full_overrun: got t=%0d f=%b o=%b exp t=%0d f=1 o=1", STRB_TOTAL, FULL, OVERRUN, MAXS);
    end
    pulse_clr();
    checks++;
    if ({STRB_TOTAL, FULL, OVERRUN} !== 8'd0) begin
      errors++; $display("FAIL full_clr: got t=%0d f=%b o=%b exp all 0", STRB_TOTAL, FULL, OVERRUN);
    end
  endtask

  task automatic test_cap_en();
    int t0;
    CAP_EN = 1'b0;
    @(negedge CLK);
    got_dat.delete(); got_cyc.delete();
    EXT_DATA = 8'h77;
`ifdef STRB_PARITY_EN
    EXT_PAR = ~(^8'h77);
`endif
    EXT_STRB = 1'b1;
    repeat (3) @(negedge CLK);
    CAP_EN = 1'b1;
    repeat (7) @(negedge CLK);
    EXT_STRB = 1'b0;
    repeat (10) @(negedge CLK);
    checks++;
    if (got_dat.size() != 0) begin errors++; $display("FAIL capen_partial: got %0d pulses exp 0", got_dat.size()); end
    checks++;
    if (STRB_TOTAL !== 6'd0) begin errors++; $display("FAIL capen_total0: got %0d exp 0", STRB_TOTAL); end
    drive_strobe(8'h3C, 8, 10, t0);
    checks++;
    if (got_dat.size() != 1) begin errors++; $display("FAIL capen_next_count: got %0d exp 1", got_dat.size()); end
    if (got_dat.size() >= 1) begin
      checks++;
      if (got_dat[0] !== 8'h3C) begin errors++; $display("FAIL capen_next_data: got %h exp 3c", got_dat[0]); end
    end
    checks++;
    if (STRB_TOTAL !== 6'd1) begin errors++; $display("FAIL capen_total1: got %0d exp 1", STRB_TOTAL); end
  endtask

  task automatic test_reset_mid();
    int t0;
    @(negedge CLK);
    got_dat.delete(); got_cyc.delete();
    EXT_DATA = 8'hC3;
`ifdef STRB_PARITY_EN
    EXT_PAR = ~(^8'hC3);
`endif
    EXT_STRB = 1'b1;
    repeat (4) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    EXT_STRB = 1'b0;
    repeat (10) @(negedge CLK);
    checks++;
    if (got_dat.size() != 0) begin errors++; $display("FAIL rstmid_count: got %0d exp 0", got_dat.size()); end
    checks++;
    if (STRB_TOTAL !== 6'd0) begin errors++; $display("FAIL rstmid_total: got %0d exp 0", STRB_TOTAL); end
    drive_strobe(8'h5A, 8, 10, t0);
    checks++;
    if (got_dat.size() != 1) begin errors++; $display("FAIL rstmid_next_count: got %0d exp 1", got_dat.size()); end
    if (got_dat.size() >= 1) begin
      checks++;
      if (got_dat[0] !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h exp 5a", got_dat[0]); end
      checks++;
      if (got_cyc[0] - t0 != LAT) begin errors++; $display("FAIL rstmid_latency: got %0d exp %0d", got_cyc[0] - t0, LAT); end
    end
  endtask

`ifdef STRB_PARITY_EN
  task automatic test_parity();
    int t0;
    pulse_clr();
    par_inv = 1'b1;
    drive_strobe(8'h01, 8, 10, t0);
    checks++;
    if (got_dat.size() != 0) begin errors++; $display("FAIL par_bad_count: got %0d exp 0", got_dat.size()); end
    checks++;
    if ({PAR_ERR_CNT, STRB_TOTAL} !== {8'd1, 6'd0}) begin
      errors++; $display("FAIL par_bad_cnt: got pe=%0d t=%0d exp pe=1 t=0", PAR_ERR_CNT, STRB_TOTAL);
    end
    par_inv = 1'b0;
    drive_strobe(8'h01, 8, 10, t0);
    checks++;
    if (got_dat.size() != 1) begin errors++; $display("FAIL par_good_count: got %0d exp 1", got_dat.size()); end
    checks++;
    if ({PAR_ERR_CNT, STRB_TOTAL} !== {8'd1, 6'd1}) begin
      errors++; $display("FAIL par_good_cnt: got pe=%0d t=%0d exp pe=1 t=1", PAR_ERR_CNT, STRB_TOTAL);
    end
  endtask
`endif

  // Frame model: a strobe either is a glitch or qualifies; a qualified enabled strobe is accepted while below MAXS, else it overruns.
  task automatic test_random();
    int t0, hold, exp_total, exp_pulse;
    logic exp_ovr, glitch, en;
    logic [7:0] d;
    pulse_clr();
    exp_total = 0;
    exp_ovr = 1'b0;
    for (int n = 0; n < 60; n++) begin
      d      = 8'($urandom);
      glitch = ($urandom_range(0, 3) == 0);
      hold   = glitch ? int'($urandom_range(1, FILT - 1)) : int'($urandom_range(FILT + 3, 12));
      en     = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) begin
        pulse_clr();
        exp_total = 0;
        exp_ovr = 1'b0;
      end
      CAP_EN = en;
      drive_strobe(d, hold, 10, t0);
      exp_pulse = 0;
      if (!glitch && en) begin
        if (exp_total < MAXS) begin
          exp_pulse = 1;
          exp_total++;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      checks++;
      if (got_dat.size() != exp_pulse) begin
        errors++; $display("FAIL rand_count n=%0d: got %0d exp %0d", n, got_dat.size(), exp_pulse);
      end
      if (exp_pulse == 1 && got_dat.size() == 1) begin
        checks++;
        if (got_dat[0] !== d || got_cyc[0] - t0 != LAT) begin
          errors++; $display("FAIL rand_pulse n=%0d: got d=%h lat=%0d exp d=%h lat=%0d", n, got_dat[0], got_cyc[0] - t0, d, LAT);
        end
      end
      checks++;
      if ({STRB_TOTAL, FULL, OVERRUN} !== {6'(exp_total), exp_total == MAXS, exp_ovr}) begin
        errors++; $display("FAIL rand_state n=%0d: got t=%0d f=%b o=%b exp t=%0d f=%b o=%b",
                           n, STRB_TOTAL, FULL, OVERRUN, exp_total, exp_total == MAXS, exp_ovr);
      end
    end
    CAP_EN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_full();
    test_cap_en();
    test_reset_mid();
`ifdef STRB_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
